// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: D->E issue control for HI/LO-class instructions in front of the
// E-stage multiply/divide unit.
//
// Holds the D->E pipeline slice (op select and both operands) and raises a D-stage
// stall whenever a HI/LO instruction would collide with an in-flight mult/div.
// A shadow latency counter tracks how long the unit should stay busy. Any
// divergence from the unit's own busy flag latches a sticky error.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   md_op_D        in   D-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                       5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 treated as none
//   rs_D, rt_D     in   forwarded operands in D
//   flush_E        in   synchronous bubble request for the E register
//   busy_E         in   busy flag from the mult/div unit
//   stall_D        out  hold D/F and insert a bubble into E (combinational)
//   mult_div_sel_E out  registered op to the mult/div unit
//   ALU_A_E        out  registered rs to the mult/div unit
//   GRF_ALU_B_E    out  registered rt to the mult/div unit
//   md_pending     out  shadow counter nonzero
//   md_err         out  sticky shadow/busy mismatch flag
module md_issue_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned SEL_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] md_op_D,
  input  logic [31:0]      rs_D,
  input  logic [31:0]      rt_D,
  input  logic             flush_E,
  input  logic             busy_E,
  output logic             stall_D,
  output logic [SEL_W-1:0] mult_div_sel_E,
  output logic [31:0]      ALU_A_E,
  output logic [31:0]      GRF_ALU_B_E,
  output logic             md_pending,
  output logic             md_err
);

  localparam int unsigned CNT_W = $clog2(DIV_LAT + 1);

  localparam logic [SEL_W-1:0] OpNone  = SEL_W'(0);
  localparam logic [SEL_W-1:0] OpMult  = SEL_W'(1);
  localparam logic [SEL_W-1:0] OpMultu = SEL_W'(2);
  localparam logic [SEL_W-1:0] OpDivu  = SEL_W'(4);
  localparam logic [SEL_W-1:0] OpMflo  = SEL_W'(8);

  localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;

  logic start_e;
  logic start_is_mul;
  logic hilo_d;

  assign start_e      = (sel_q >= OpMult) && (sel_q <= OpDivu);
  assign start_is_mul = (sel_q == OpMult) || (sel_q == OpMultu);
  assign hilo_d       = (md_op_D >= OpMult) && (md_op_D <= OpMflo);

  assign md_pending = (cnt_q != '0);
  // A start sitting in E counts as busy: the unit only raises busy_E a cycle later.
  assign stall_D    = hilo_d & (busy_E | start_e | md_pending);

  // E register: bubble on stall or flush, otherwise capture D (undefined ops become none).
  always_comb begin
    sel_d = sel_q;
    a_d   = a_q;
    b_d   = b_q;
    if (stall_D || flush_E) begin
      sel_d = OpNone;
      a_d   = '0;
      b_d   = '0;
    end else begin
      sel_d = (md_op_D <= OpMflo) ? md_op_D : OpNone;
      a_d   = rs_D;
      b_d   = rt_D;
    end
  end

  // Shadow latency tracker. The counter is loaded with the full latency so
  // that md_pending covers exactly the unit's busy window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q | (md_pending != busy_E);
    unique case (state_q)
      StIdle: begin
        if (start_e) begin
          state_d = start_is_mul ? StMul : StDiv;
          cnt_d   = start_is_mul ? MulLoad : DivLoad;
        end
      end
      StMul, StDiv: begin
        if (start_e) begin
          // Only reachable if the stall was bypassed; flag it and track the new op.
          err_d   = 1'b1;
          state_d = start_is_mul ? StMul : StDiv;
          cnt_d   = start_is_mul ? MulLoad : DivLoad;
        end else if (cnt_q == CntOne) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      sel_q   <= OpNone;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign mult_div_sel_E = sel_q;
  assign ALU_A_E        = a_q;
  assign GRF_ALU_B_E    = b_q;
  assign md_err         = err_q;

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Upstream neighbour of the E-stage multiply/divide unit. Holds the D→E pipeline slice for HI/LO-class instructions: op select and both operands.
- Generates the D-stage stall for any HI/LO instruction that would collide with an in-flight mult/div.
- Runs a shadow latency counter that cross-checks the unit's busy flag and flags any divergence.

Parameters:
MULT_LAT, 5, cycles busy_E stays high after a mult/multu issue
DIV_LAT, 10, cycles busy_E stays high after a div/divu issue
SEL_W, 4, width of op select

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
md_op_D  in  SEL_W  D-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 treated as none
rs_D  in  32  forwarded rs value in D
rt_D  in  32  forwarded rt value in D
flush_E  in  1  synchronous bubble request for the E register
busy_E  in  1  busy flag from the mult/div unit
stall_D  out  1  hold D/F, insert bubble into E (combinational)
mult_div_sel_E  out  SEL_W  registered op to the mult/div unit
ALU_A_E  out  32  registered rs to the mult/div unit
GRF_ALU_B_E  out  32  registered rt to the mult/div unit
md_pending  out  1  shadow counter nonzero
md_err  out  1  sticky: shadow/busy mismatch seen

Behaviour:
- Reset (reset=0, async): mult_div_sel_E=0, ALU_A_E=0, GRF_ALU_B_E=0, cnt=0, state=IDLE, md_err=0. Outputs are immediately valid. Reset mid-operation drops all pending state; busy_E from the unit is not awaited.
- Definitions:
  - start_E = mult_div_sel_E in {1,2,3,4}.
  - hilo_D = md_op_D in {1..8}.
- stall_D = hilo_D & (busy_E | start_E | md_pending). It is purely combinational and never asserted for ops 0 or 9-15.
- E register update on each rising edge:
  - If stall_D or flush_E: load bubble (sel=0, operands 0).
  - Otherwise: capture md_op_D (values 9-15 are written as 0), rs_D and rt_D.
  - flush_E and stall_D together produce a single bubble.
- Shadow FSM. States IDLE, MUL, DIV. cnt is 4 bits, sized for DIV_LAT.
  - IDLE: if start_E, go to MUL (ops 1,2) with cnt=MULT_LAT, or to DIV (ops 3,4) with cnt=DIV_LAT.
  - MUL/DIV: cnt decrements each edge. Leaving cnt=1 returns to IDLE with cnt=0.
  - A start_E while not in IDLE cannot occur, because the stall prevents it. If it does occur, set md_err and reload per the new op.
  - md_pending = (cnt != 0).
- Timing: a start in E during cycle N gives md_pending high in cycles N+1..N+MULT_LAT (or N+DIV_LAT). This matches the unit's busy window exactly.
- md_err: set at any edge where md_pending != busy_E. It stays set until reset.
- mthi/mtlo/mfhi/mflo always wait until both busy_E and md_pending are low and no start is in E.
- The block does no arithmetic. Operands pass through unmodified at 32 bits.

Test Plan:
- Reset low mid-run with cnt=7 → all outputs 0 immediately, md_err=0. After release, md_op_D=0 → stall_D=0.
- Issue mult with rs_D=32'h0000_0003, rt_D=32'hFFFF_FFFE at cycle 0 (sel_E=1 in cycle 1) → md_pending high in cycles 2-6. Model busy_E matches, so md_err stays 0.
- div in E, then mflo presented in D every cycle → stall_D high from the cycle div is in E through the last busy cycle (11 cycles total). sel_E is 0 in each of those cycles. mflo enters E (sel_E=8) on the first cycle after the stall releases.
- Back-to-back mult then multu in D → multu stalls 6 cycles (1 start + 5 busy), then sel_E=2 with operands intact.
- flush_E=1 with md_op_D=1 → sel_E=0 next cycle, no FSM transition, md_pending stays 0.
- Force busy_E=0 while md_pending=1 → md_err=1 next edge and it stays 1 through later ops until reset.
